// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch-stage definitions: widths,
// opcodes and the halt encoding.
package fetch_prefetch_unit_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [15:0] HALT_WORD = 16'h0000;

  typedef enum logic [3:0] {
    OP_JZ   = 4'h0,
    OP_JMP  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_LD   = 4'h9,
    OP_LI   = 4'hA,
    OP_ST   = 4'hB,
    OP_MOV  = 4'hC,
    OP_CMP  = 4'hD,
    OP_MUL  = 4'hE,
    OP_MULF = 4'hF
  } opcode_e;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch word FIFO: single push, pop of
// 0..2 words, flush, head/head+1 peek.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic [1:0]    pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head,
  output logic [W-1:0]  head1
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic [CW-1:0] cnt;

  assign count = cnt;
  assign head  = mem[rp];
  assign head1 = mem[rp + AW'(1)];

  // pointer/count update; flush wins over push and pop
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + AW'(1);
      end
      rp  <= rp + AW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // fetch credit keeps a push away from a full buffer
  always_ff @(posedge clk) begin
    assert (clr || flush || !push ||
            cnt != CW'(DEPTH))
      else $error("fetch_fifo overflow");
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch: imem streaming into the
// prefetch FIFO, LI pairing, redirect, halt.
module fetch_prefetch_unit #(
  parameter int WORD_W = fetch_prefetch_unit_pkg::WORD_W,
  parameter int ADDR_W = fetch_prefetch_unit_pkg::ADDR_W,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [WORD_W-1:0] dec_instr,
  output logic [WORD_W-1:0] dec_imm,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halt
);

  import fetch_prefetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] head_pc;
  logic              inflight;
  logic              stopped;
  logic              halt_q;
  logic [CW-1:0]     count;
  logic [WORD_W-1:0] head;
  logic [WORD_W-1:0] head1;
  logic              redir;
  logic              push;
  logic              accept;
  logic              li;
  logic              pair_rdy;
  logic [1:0]        pop;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .flush (redir),
    .push  (push),
    .wdata (imem_rdata),
    .pop   (pop),
    .count (count),
    .head  (head),
    .head1 (head1)
  );

  assign redir    = redirect_valid & ~halt_q;
  assign imem_req = ~clr & ~stopped & ~halt_q &
                    ~redirect_valid &
                    ((int'(count) + int'(inflight))
                     < DEPTH);
  assign imem_addr = fetch_pc;
  assign push      = inflight & ~redir;

  assign li        = head[WORD_W-1 -: 4] == OP_LI;
  assign pair_rdy  = count >= CW'(2);
  assign dec_valid = ~halt_q &
                     (li ? pair_rdy : count != '0);
  assign dec_instr = (count != '0) ? head : '0;
  assign dec_imm   = (li && pair_rdy) ? head1 : '0;
  assign dec_pc    = head_pc;
  assign halt      = halt_q;

  assign accept = dec_valid & dec_ready & ~redir;
  assign pop    = accept ? (li ? 2'd2 : 2'd1)
                         : 2'd0;

  // fetch/head pointers, return tracking, halt
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      inflight <= 1'b0;
      stopped  <= 1'b0;
      halt_q   <= 1'b0;
    end else if (redir) begin
      fetch_pc <= redirect_pc;
      head_pc  <= redirect_pc;
      inflight <= 1'b0;
      stopped  <= 1'b0;
    end else begin
      if (imem_req)
        fetch_pc <= fetch_pc + ADDR_W'(1);
      inflight <= imem_req;
      head_pc  <= head_pc + ADDR_W'(pop);
      if (push &&
          imem_rdata == WORD_W'(HALT_WORD))
        stopped <= 1'b1;
      if (accept &&
          head == WORD_W'(HALT_WORD))
        halt_q <= 1'b1;
    end
  end

endmodule
